// File: rtl/axis_if.sv
// Valid/ready beat stream carrying data and a packet-end marker.
// The master drives data/vld/last; the slave drives rdy.
interface axis_if #(
    parameter int unsigned DATAW = 64
) ();

    logic [DATAW-1:0] data;
    logic             vld;
    logic             last;
    logic             rdy;

    modport master (
        output data,
        output vld,
        output last,
        input  rdy
    );

    modport slave (
        input  data,
        input  vld,
        input  last,
        output rdy
    );

endinterface

// File: rtl/axis_pkt_chk.sv
// Stream sink that frames packets of N beats by last, reports per-packet XOR checksums,
// flags early/missing last, keeps saturating counters and optionally throttles rdy.
module axis_pkt_chk #(
    parameter int unsigned N         = 16,
    parameter int unsigned DATAW     = 64,
    parameter int unsigned BP_PERIOD = 0
) (
    input  logic             clk,
    input  logic             s_rst_n,
    axis_if.slave            s_axis,
    input  logic             clr,
    output logic             pkt_done,
    output logic [DATAW-1:0] pkt_csum,
    output logic             beat_err,
    output logic [1:0]       err_code,
    output logic [31:0]      pkt_cnt,
    output logic [15:0]      err_cnt
);

    localparam int unsigned     IdxW    = $clog2(N);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

    localparam logic [1:0] ErrEarly   = 2'b01;
    localparam logic [1:0] ErrMissing = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StInPkt
    } state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [DATAW-1:0] acc_q, acc_d;
    logic [DATAW-1:0] csum_q, csum_d;
    logic             done_q, done_d;
    logic             berr_q, berr_d;
    logic [1:0]       code_q, code_d;
    logic [31:0]      pcnt_q, pcnt_d;
    logic [15:0]      ecnt_q, ecnt_d;
    logic             rdy_q, rdy_d;

    logic accept;
    logic at_last;
    logic close;
    logic good;
    logic early;
    logic missing;

    assign accept  = s_axis.vld & rdy_q;
    assign at_last = (idx_q == IdxLast);
    assign close   = accept & (s_axis.last | at_last);
    assign good    = close & s_axis.last & at_last;
    assign early   = close & s_axis.last & ~at_last;
    assign missing = close & ~s_axis.last & at_last;

    // Framing FSM: idx is the index of the next beat to be accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !close) begin
                    state_d = StInPkt;
                    idx_d   = idx_q + 1'b1;
                end
            end
            StInPkt: begin
                if (accept) begin
                    if (close) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (close) begin
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_q ^ s_axis.data;
        end
    end

    always_comb begin
        done_d = close;
        berr_d = early | missing;
        csum_d = close ? (acc_q ^ s_axis.data) : csum_q;
    end

    // Status and counters: clr takes priority over any coincident update.
    always_comb begin
        code_d = code_q;
        pcnt_d = pcnt_q;
        ecnt_d = ecnt_q;
        if (clr) begin
            code_d = '0;
            pcnt_d = '0;
            ecnt_d = '0;
        end else begin
            if (early) begin
                code_d = ErrEarly;
            end else if (missing) begin
                code_d = ErrMissing;
            end
            if (good && (pcnt_q != '1)) begin
                pcnt_d = pcnt_q + 32'd1;
            end
            if ((early || missing) && (ecnt_q != '1)) begin
                ecnt_d = ecnt_q + 16'd1;
            end
        end
    end

    generate
        if (BP_PERIOD == 0) begin : g_no_bp
            assign rdy_d = 1'b1;
        end else begin : g_bp
            localparam int unsigned    BpW    = $clog2(BP_PERIOD);
            localparam logic [BpW-1:0] BpLast = BpW'(BP_PERIOD - 1);

            logic [BpW-1:0] bp_q, bp_d;

            always_comb begin
                bp_d  = (bp_q == BpLast) ? '0 : bp_q + 1'b1;
                rdy_d = (bp_q != BpLast);
            end

            always_ff @(posedge clk) begin
                if (!s_rst_n) begin
                    bp_q <= '0;
                end else begin
                    bp_q <= bp_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            berr_q  <= 1'b0;
            code_q  <= '0;
            pcnt_q  <= '0;
            ecnt_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            berr_q  <= berr_d;
            code_q  <= code_d;
            pcnt_q  <= pcnt_d;
            ecnt_q  <= ecnt_d;
            rdy_q   <= rdy_d;
        end
    end

    assign s_axis.rdy = rdy_q;
    assign pkt_done   = done_q;
    assign pkt_csum   = csum_q;
    assign beat_err   = berr_q;
    assign err_code   = code_q;
    assign pkt_cnt    = pcnt_q;
    assign err_cnt    = ecnt_q;

    // A framing error always closes the packet it belongs to.
    a_err_closes: assert property (@(posedge clk) disable iff (!s_rst_n) beat_err |-> pkt_done);
    a_idle_idx:   assert property (@(posedge clk) disable iff (!s_rst_n)
                                   (state_q == StIdle) |-> (idx_q == '0));

endmodule

// File: tb/tb_axis_pkt_chk.sv
// Directed bench: an N=4 always-ready checker driven from a vector table plus corner
// sequences, and an N=16 checker with BP_PERIOD=4 fed by a ready-respecting generator.
module tb_axis_pkt_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- N=4, no back-pressure ----------------
    logic        rst4_n;
    logic        clr4;
    logic        done4, berr4;
    logic [63:0] csum4;
    logic [1:0]  code4;
    logic [31:0] pcnt4;
    logic [15:0] ecnt4;

    axis_if #(.DATAW(64)) ax4 ();

    axis_pkt_chk #(.N(4), .DATAW(64), .BP_PERIOD(0)) u_dut4 (
        .clk      (clk),
        .s_rst_n  (rst4_n),
        .s_axis   (ax4.slave),
        .clr      (clr4),
        .pkt_done (done4),
        .pkt_csum (csum4),
        .beat_err (berr4),
        .err_code (code4),
        .pkt_cnt  (pcnt4),
        .err_cnt  (ecnt4)
    );

    // ---------------- N=16, BP_PERIOD=4 ----------------
    logic        rst16_n;
    logic        clr16;
    logic        done16, berr16;
    logic [63:0] csum16;
    logic [1:0]  code16;
    logic [31:0] pcnt16;
    logic [15:0] ecnt16;

    axis_if #(.DATAW(64)) ax16 ();

    axis_pkt_chk #(.N(16), .DATAW(64), .BP_PERIOD(4)) u_dut16 (
        .clk      (clk),
        .s_rst_n  (rst16_n),
        .s_axis   (ax16.slave),
        .clr      (clr16),
        .pkt_done (done16),
        .pkt_csum (csum16),
        .beat_err (berr16),
        .err_code (code16),
        .pkt_cnt  (pcnt16),
        .err_cnt  (ecnt16)
    );

    typedef struct {
        logic        vld;
        logic        last;
        logic [63:0] data;
        logic        done;
        logic        err;
        logic [63:0] csum;
        logic [1:0]  code;
        logic [31:0] pcnt;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic last, input logic [63:0] data,
                                input logic done, input logic err, input logic [63:0] csum,
                                input logic [1:0] code, input logic [31:0] pcnt,
                                input logic [15:0] ecnt);
        vec_t v;
        v.vld  = vld;
        v.last = last;
        v.data = data;
        v.done = done;
        v.err  = err;
        v.csum = csum;
        v.code = code;
        v.pcnt = pcnt;
        v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the N=4 checker; outputs are inspected #1 after the edge.
    task automatic beat4(input logic vld, input logic last, input logic [63:0] data,
                         input logic clr);
        ax4.vld  = vld;
        ax4.last = last;
        ax4.data = data;
        clr4     = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          done_pulses;
        int          mbp;
        int          rdy_bad;
        int          done_bad;
        int          lows;
        int          lasts;
        int          gbeat;
        logic        exp_rdy;
        logic        acc_now;
        logic        lst;
        logic [63:0] d;
        logic [63:0] xacc;
        logic [63:0] gdata;

        // Good, early-last, ignored idle, missing-last, single-beat and full-width packets.
        vecs.push_back(mk(1, 0, 64'h1,  0, 0, 64'h0,  2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 64'h2,  0, 0, 64'h0,  2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 64'h4,  0, 0, 64'h0,  2'b00, 0, 0));
        vecs.push_back(mk(1, 1, 64'h8,  1, 0, 64'hF,  2'b00, 1, 0));
        vecs.push_back(mk(1, 0, 64'hA,  0, 0, 64'hF,  2'b00, 1, 0));
        vecs.push_back(mk(1, 1, 64'h5,  1, 1, 64'hF,  2'b01, 1, 1));
        vecs.push_back(mk(1, 0, 64'h10, 0, 0, 64'hF,  2'b01, 1, 1));
        vecs.push_back(mk(1, 0, 64'h20, 0, 0, 64'hF,  2'b01, 1, 1));
        vecs.push_back(mk(1, 0, 64'h40, 0, 0, 64'hF,  2'b01, 1, 1));
        vecs.push_back(mk(1, 1, 64'h80, 1, 0, 64'hF0, 2'b01, 2, 1));
        vecs.push_back(mk(0, 1, 64'hFFFF, 0, 0, 64'hF0, 2'b01, 2, 1));
        vecs.push_back(mk(1, 0, 64'h1,  0, 0, 64'hF0, 2'b01, 2, 1));
        vecs.push_back(mk(1, 0, 64'h2,  0, 0, 64'hF0, 2'b01, 2, 1));
        vecs.push_back(mk(1, 0, 64'h3,  0, 0, 64'hF0, 2'b01, 2, 1));
        vecs.push_back(mk(1, 0, 64'h4,  1, 1, 64'h4,  2'b10, 2, 2));
        vecs.push_back(mk(1, 0, 64'h5,  0, 0, 64'h4,  2'b10, 2, 2));
        vecs.push_back(mk(1, 0, 64'h6,  0, 0, 64'h4,  2'b10, 2, 2));
        vecs.push_back(mk(1, 0, 64'h7,  0, 0, 64'h4,  2'b10, 2, 2));
        vecs.push_back(mk(1, 1, 64'h8,  1, 0, 64'hC,  2'b10, 3, 2));
        vecs.push_back(mk(1, 1, 64'h55, 1, 1, 64'h55, 2'b01, 3, 3));
        vecs.push_back(mk(1, 0, 64'hFFFF_0000_FFFF_0000, 0, 0, 64'h55, 2'b01, 3, 3));
        vecs.push_back(mk(1, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h55, 2'b01, 3, 3));
        vecs.push_back(mk(1, 0, 64'h0, 0, 0, 64'h55, 2'b01, 3, 3));
        vecs.push_back(mk(1, 1, 64'h8000_0000_0000_0000, 1, 0, 64'h7EDC_4567_7654_CDEF,
                          2'b01, 4, 3));

        rst4_n   = 1'b0;
        rst16_n  = 1'b0;
        clr4     = 1'b0;
        clr16    = 1'b0;
        ax4.vld  = 1'b0;
        ax4.last = 1'b0;
        ax4.data = '0;
        ax16.vld  = 1'b0;
        ax16.last = 1'b0;
        ax16.data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset rdy",      64'(ax4.rdy), 64'h0);
        chk("reset pkt_done", 64'(done4),   64'h0);
        chk("reset beat_err", 64'(berr4),   64'h0);
        chk("reset pkt_csum", csum4,        64'h0);
        chk("reset err_code", 64'(code4),   64'h0);
        chk("reset pkt_cnt",  64'(pcnt4),   64'h0);
        chk("reset err_cnt",  64'(ecnt4),   64'h0);
        chk("reset rdy bp",   64'(ax16.rdy), 64'h0);

        rst4_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy after reset", 64'(ax4.rdy), 64'h1);

        foreach (vecs[i]) begin
            beat4(vecs[i].vld, vecs[i].last, vecs[i].data, 1'b0);
            chk($sformatf("vec%0d pkt_done", i), 64'(done4), 64'(vecs[i].done));
            chk($sformatf("vec%0d beat_err", i), 64'(berr4), 64'(vecs[i].err));
            chk($sformatf("vec%0d pkt_csum", i), csum4,      vecs[i].csum);
            chk($sformatf("vec%0d err_code", i), 64'(code4), 64'(vecs[i].code));
            chk($sformatf("vec%0d pkt_cnt",  i), 64'(pcnt4), 64'(vecs[i].pcnt));
            chk($sformatf("vec%0d err_cnt",  i), 64'(ecnt4), 64'(vecs[i].ecnt));
        end

        // clr on the same cycle as a good close: pulse still fires, counters read 0.
        beat4(1'b1, 1'b0, 64'h1, 1'b0);
        beat4(1'b1, 1'b0, 64'h2, 1'b0);
        beat4(1'b1, 1'b0, 64'h3, 1'b0);
        beat4(1'b1, 1'b1, 64'h4, 1'b1);
        chk("clr collision pkt_done", 64'(done4), 64'h1);
        chk("clr collision pkt_csum", csum4,      64'h4);
        chk("clr collision pkt_cnt",  64'(pcnt4), 64'h0);
        chk("clr collision err_cnt",  64'(ecnt4), 64'h0);
        chk("clr collision err_code", 64'(code4), 64'h0);
        beat4(1'b0, 1'b0, 64'h0, 1'b0);
        chk("after clr pkt_done", 64'(done4), 64'h0);
        chk("after clr pkt_cnt",  64'(pcnt4), 64'h0);

        // Reset in the middle of a packet discards the partial beats.
        beat4(1'b1, 1'b0, 64'h1, 1'b0);
        beat4(1'b1, 1'b0, 64'h2, 1'b0);
        ax4.vld = 1'b0;
        rst4_n  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset rdy",      64'(ax4.rdy), 64'h0);
        chk("mid reset pkt_done", 64'(done4),   64'h0);
        rst4_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset rdy", 64'(ax4.rdy), 64'h1);
        done_pulses = 0;
        beat4(1'b1, 1'b0, 64'h1, 1'b0);
        done_pulses += int'(done4);
        beat4(1'b1, 1'b0, 64'h2, 1'b0);
        done_pulses += int'(done4);
        beat4(1'b1, 1'b0, 64'h4, 1'b0);
        done_pulses += int'(done4);
        beat4(1'b1, 1'b1, 64'h8, 1'b0);
        done_pulses += int'(done4);
        chk("post reset pkt_csum", csum4, 64'hF);
        beat4(1'b0, 1'b0, 64'h0, 1'b0);
        done_pulses += int'(done4);
        chk("post reset done pulses", 64'(done_pulses), 64'h1);
        chk("post reset pkt_cnt",     64'(pcnt4),       64'h1);
        chk("post reset err_cnt",     64'(ecnt4),       64'h0);

        // Back-pressure: generator holds each beat until rdy accepts it.
        gdata     = 64'h1234_5678_9ABC_DEF1;
        gbeat     = 0;
        ax16.vld  = 1'b1;
        ax16.data = gdata;
        ax16.last = 1'b0;
        rst16_n   = 1'b1;
        mbp       = 0;
        rdy_bad   = 0;
        done_bad  = 0;
        lows      = 0;
        lasts     = 0;
        xacc      = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            acc_now = ax16.vld && ax16.rdy;
            lst     = ax16.last;
            d       = ax16.data;
            @(posedge clk);
            #1;
            exp_rdy = (mbp != 3);
            mbp     = (mbp == 3) ? 0 : mbp + 1;
            if (ax16.rdy !== exp_rdy) rdy_bad++;
            if (ax16.rdy === 1'b0) lows++;
            if (done16 !== (acc_now && lst)) done_bad++;
            if (acc_now) begin
                xacc = xacc ^ d;
                if (lst) begin
                    chk($sformatf("bp pkt%0d pkt_csum", lasts), csum16, xacc);
                    xacc = '0;
                    lasts++;
                    gbeat = 0;
                end else begin
                    gbeat++;
                end
                gdata     = xs64(gdata);
                ax16.data = gdata;
                ax16.last = (gbeat == 15);
            end
        end
        chk("bp rdy pattern mismatches", 64'(rdy_bad),  64'h0);
        chk("bp rdy low cycles",         64'(lows),     64'd250);
        chk("bp pkt_done mismatches",    64'(done_bad), 64'h0);
        chk("bp pkt_cnt vs lasts",       64'(pcnt16),   64'(lasts));
        chk("bp err_cnt",                64'(ecnt16),   64'h0);
        chk("bp beat_err idle",          64'(berr16),   64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_chk.md
# axis_pkt_chk

Stream sink and packet checker downstream of the LFSR stream generator in the fv_enc test path. It accepts beats on an `axis_if` slave port and optionally throttles `rdy` to exercise the generator's ready-checking mode. It frames packets by `last` against the expected length N and produces a per-packet XOR checksum. It also keeps saturating packet and error counters for the bench and the debug registers.

## Interface
- `N`, 16: expected beats per packet; must be ≥ 2.
- `DATAW`, 64: data width; must match the generator.
- `BP_PERIOD`, 0: back-pressure period. `rdy` is low for 1 cycle in every `BP_PERIOD` cycles. 0 means always ready. `BP_PERIOD`=1 is illegal.
- `clk`  in  1  clock.
- `s_rst_n`  in  1  synchronous, active-low reset.
- `s_axis`  axis_if.in  —  carries `data[DATAW]`, `vld`, `last` from upstream; `rdy` is driven by this block.
- `clr`  in  1  synchronous clear of counters and error status; has no effect on framing.
- `pkt_done`  out  1  one-cycle pulse when a packet closes.
- `pkt_csum`  out  DATAW  XOR of all accepted beats of the closed packet; valid while `pkt_done`=1, held otherwise.
- `beat_err`  out  1  one-cycle pulse on a framing error.
- `err_code`  out  2  cause of the last error: 01 = early last, 10 = missing last. Sticky until `clr`.
- `pkt_cnt`  out  32  packets closed without error; saturates at 0xFFFF_FFFF.
- `err_cnt`  out  16  framing errors; saturates at 0xFFFF.

## Operation
- **Transfer:** a beat is accepted only when `vld` && `rdy` in the same cycle. `vld` without `rdy` is ignored, and the data is not sampled.
- **Beat index:** `idx` is $clog2(N) bits wide and starts at 0.
- **State machine:**
  - IDLE: `idx`=0. An accepted beat moves to IN_PKT.
  - IN_PKT: each accepted beat advances `idx`.
  - A single-beat packet can close straight from IDLE.
- **Packet close:** on an accepted beat at index i, the packet closes when (`last`=1) or (i = N-1).
  - `last`=1 and i = N-1: good packet. `pkt_done`=1 and `pkt_cnt` increments.
  - `last`=1 and i < N-1: early last. `pkt_done`=1, `beat_err`=1, `err_code`=01, `err_cnt` increments, `pkt_cnt` unchanged.
  - `last`=0 and i = N-1: missing last. Same as early last, except `err_code`=10. The next beat starts a new packet at index 0.
  - On every close: `idx` returns to 0, state returns to IDLE, and `pkt_csum` is loaded with `acc ^ data`.
- **Checksum:** `acc` resets to 0. It is XORed with `data` on each accepted beat and cleared to 0 on close.
- **Back-pressure:**
  - Free-running cycle counter `bp` counts 0..`BP_PERIOD`-1 and wraps.
  - `rdy` is registered: next `rdy` = !(`bp` == `BP_PERIOD`-1).
  - With `BP_PERIOD`=0, next `rdy` = 1.
- **Clear:** `clr`=1 zeroes `pkt_cnt`, `err_cnt` and `err_code` next cycle.
  - If a counter increment coincides with `clr`, the clear wins: the counter reads 0.
  - Framing state, `acc`, `pulses` and `pkt_csum` are unaffected by `clr`.

## Timing
- **Reset values:** `rdy`=0, `pkt_done`=0, `beat_err`=0, `pkt_csum`=0, `err_code`=0, `pkt_cnt`=0, `err_cnt`=0. Internally, state=IDLE, `idx`=0, `acc`=0, `bp`=0.
- `rdy` rises on the first clock edge after `s_rst_n` deasserts, or follows the `bp` pattern if back-pressure is enabled.
- **Latency:**
  - `pkt_done`, `beat_err` and `pkt_csum` are registered. They are valid 1 cycle after the closing beat's accept edge.
  - Counters update on that same edge.
- **Reset mid-packet:** the partial packet is discarded with no pulse and no count. The next accepted beat has index 0.
- **Throughput:** no bubbles are inserted other than the back-pressure cycles. Back-to-back packets at 1 beat/cycle are supported.
- Saturated counters hold their maximum value. `clr` still zeroes them.

## Test plan
- **Good packet:** `BP_PERIOD`=0, N=4. Send beats 1, 2, 4, 8 with `last` on beat 3 → one `pkt_done` pulse, `pkt_csum`=0xF, `pkt_cnt`=1, `beat_err` never asserts.
- **Early last:** N=4. Send 2 beats (0xA, 0x5) with `last` on beat 1 → `pkt_done`+`beat_err`, `err_code`=01, `pkt_csum`=0xF, `err_cnt`=1, `pkt_cnt`=0. The next 4-beat packet is good.
- **Missing last:** N=4. Send 6 beats with no `last` → error pulse after beat 3 with `err_code`=10. Beats 4–5 are counted as indices 0–1 of a new packet.
- **Back-pressure:** `BP_PERIOD`=4 with the generator in ready-checking mode (its `MODE` parameter = 0), N=16. Run 1000 cycles → `rdy` is low exactly every 4th cycle, `pkt_cnt` equals the number of generator `last` beats accepted, `err_cnt`=0.
- **Clear collision:** assert `clr` on the same cycle as a good close → `pkt_cnt` reads 0 on the following cycle, and the `pkt_done` pulse still occurs.
- **Reset mid-packet:** after 2 beats of an N=4 packet, pulse `s_rst_n` low for 1 cycle, then send a good 4-beat packet → exactly one `pkt_done`, `pkt_cnt`=1, `err_cnt`=0, and `rdy`=0 during the reset cycle.
